// File: rtl/lfsr_rand_gen_if.sv
// ---------------------------------------------------------------------------
// lfsr_rand_gen_if
//
// Purpose:
//   Groups the control, seed and ready/valid output signals of the LFSR
//   random generator into one bundle. Clock and reset are not part of this
//   interface. They stay plain ports on the generator.
//
// Signals:
//   enable       run request; low pauses generation with the state held
//   seed_load    load seed_in into the generator state this cycle
//   seed_in      [WIDTH] seed value used by seed_load
//   rand_ready   consumer accepts rand_out while rand_valid is high
//   rand_out     [WIDTH] current LFSR state
//   rand_valid   rand_out holds a usable value
//   lockup       generator is stalled on the all-zero state
//   period_done  one-cycle pulse when the sequence returns to its seed
//   step_count   [16] accepted outputs since the last seed load or reset
//
// Modports:
//   master  consumer / controller side (drives the requests)
//   slave   generator side (drives the results)
// ---------------------------------------------------------------------------
interface lfsr_rand_gen_if #(
    parameter int unsigned WIDTH = 6
);

    logic             enable;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             rand_ready;
    logic [WIDTH-1:0] rand_out;
    logic             rand_valid;
    logic             lockup;
    logic             period_done;
    logic [15:0]      step_count;

    modport master (
        output enable,
        output seed_load,
        output seed_in,
        output rand_ready,
        input  rand_out,
        input  rand_valid,
        input  lockup,
        input  period_done,
        input  step_count
    );

    modport slave (
        input  enable,
        input  seed_load,
        input  seed_in,
        input  rand_ready,
        output rand_out,
        output rand_valid,
        output lockup,
        output period_done,
        output step_count
    );

endinterface

// File: rtl/lfsr_rand_gen.sv
// ---------------------------------------------------------------------------
// lfsr_rand_gen
//
// Purpose:
//   Pseudo-random generator built on a WIDTH-bit LFSR. Each value is offered
//   on a ready/valid handshake. The register steps once per accepted output.
//   It supports Fibonacci or Galois feedback, a runtime seed load, detection
//   of the all-zero lockup state, a period-complete pulse and a saturating
//   count of accepted outputs.
//
// Parameters:
//   WIDTH  LFSR width, legal 3..32
//   TAPS   feedback tap mask, WIDTH bits
//   MODE   0 = Fibonacci, 1 = Galois
//   SEED   reset state. It must be non-zero or the generator starts locked.
//
// Ports:
//   clk    single clock. All state updates happen on the rising edge.
//   rst_n  asynchronous, active-low reset
//   bus    lfsr_rand_gen_if.slave. See the interface file for each signal.
// ---------------------------------------------------------------------------
module lfsr_rand_gen #(
    parameter int unsigned      WIDTH = 6,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(6'b000011),
    parameter int unsigned      MODE  = 0,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(6'b000001)
) (
    input  logic            clk,
    input  logic            rst_n,
    lfsr_rand_gen_if.slave  bus
);

    // Generator control states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t           r_fsm;
    state_t           w_fsm_next;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_seed;
    logic             r_period_done;
    logic [15:0]      r_step_count;

    logic [WIDTH-1:0] w_lfsr_next;
    logic             w_accept;
    logic             w_seed_zero;
    logic             w_next_zero;
    logic             w_step_sat;

    // The feedback style is fixed when the design is built. Only one of the
    // two step functions exists in hardware.
    generate
        if (MODE == 0) begin : g_fibonacci
            // The XOR of the tapped bits enters at the MSB. The rest of the
            // register shifts toward the LSB.
            assign w_lfsr_next = {^(r_lfsr & TAPS), r_lfsr[WIDTH-1:1]};
        end else begin : g_galois
            // The bit shifted out of the LSB toggles every tapped position.
            assign w_lfsr_next = (r_lfsr >> 1) ^ ({WIDTH{r_lfsr[0]}} & TAPS);
        end
    endgenerate

    // An output is consumed only while RUN offers it and the consumer takes
    // it. A seed load in the same cycle overrides the step, so that
    // handshake does not advance the register.
    assign w_accept    = (r_fsm == S_RUN) && bus.rand_ready && !bus.seed_load;
    assign w_seed_zero = (bus.seed_in == '0);
    assign w_next_zero = (w_lfsr_next == '0);
    assign w_step_sat  = (r_step_count == 16'hFFFF);

    // Next-state logic. A seed load overrides every other transition. LOCK
    // is left only through a seed load, because stepping cannot leave zero.
    always_comb begin
        w_fsm_next = r_fsm;
        if (bus.seed_load) begin
            if (!bus.enable) begin
                w_fsm_next = S_IDLE;
            end else if (w_seed_zero) begin
                w_fsm_next = S_LOCK;
            end else begin
                w_fsm_next = S_RUN;
            end
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (bus.enable) begin
                        w_fsm_next = (r_lfsr != '0) ? S_RUN : S_LOCK;
                    end
                end
                S_RUN: begin
                    // Stepping into zero can happen only with non-maximal
                    // taps. That takes priority over pausing, because the
                    // generator cannot recover from zero on its own.
                    if (w_accept && w_next_zero) begin
                        w_fsm_next = S_LOCK;
                    end else if (!bus.enable) begin
                        w_fsm_next = S_IDLE;
                    end
                end
                S_LOCK: begin
                    w_fsm_next = S_LOCK;
                end
                default: begin
                    w_fsm_next = S_IDLE;
                end
            endcase
        end
    end

    // State register for the control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // LFSR datapath and bookkeeping. A seed load replaces both the live
    // state and the reference seed that period detection compares against.
    // An accepted output steps the register once. period_done is recomputed
    // every cycle, so it is high for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr        <= SEED;
            r_seed        <= SEED;
            r_period_done <= 1'b0;
            r_step_count  <= 16'd0;
        end else if (bus.seed_load) begin
            r_lfsr        <= bus.seed_in;
            r_seed        <= bus.seed_in;
            r_period_done <= 1'b0;
            r_step_count  <= 16'd0;
        end else if (w_accept) begin
            r_lfsr        <= w_lfsr_next;
            r_period_done <= (w_lfsr_next == r_seed);
            // Completing a period does not clear the count. The count stops
            // at all-ones instead of wrapping back to zero.
            if (!w_step_sat) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end else begin
            r_period_done <= 1'b0;
        end
    end

    // The status outputs decode the registered FSM state. rand_out shows the
    // register directly, so it stays stable while the consumer withholds
    // ready.
    assign bus.rand_out    = r_lfsr;
    assign bus.rand_valid  = (r_fsm == S_RUN);
    assign bus.lockup      = (r_fsm == S_LOCK);
    assign bus.period_done = r_period_done;
    assign bus.step_count  = r_step_count;

endmodule

// File: doc/lfsr_rand_gen.md
LFSR_RAND_GEN -- requirements
Module: lfsr_rand_gen

Interface
REQ-001 Parameter WIDTH, default 6: LFSR state width, legal 3..32.
REQ-002 Parameter TAPS, default 6'b000011 (WIDTH bits): feedback tap mask.
REQ-003 Parameter MODE, default 0: 0 = Fibonacci, 1 = Galois.
REQ-004 Parameter SEED, default 6'b000001 (WIDTH bits): reset state, SHALL be non-zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  run request; low pauses generation with state held.
REQ-008 seed_load  input  1  load seed_in into state this cycle.
REQ-009 seed_in  input  WIDTH  seed value for seed_load.
REQ-010 rand_ready  input  1  consumer accepts rand_out when rand_valid is high.
REQ-011 rand_out  output  WIDTH  current LFSR state, registered.
REQ-012 rand_valid  output  1  rand_out is valid.
REQ-013 lockup  output  1  state is all-zero and the generator is stalled.
REQ-014 period_done  output  1  one-cycle pulse when the state returns to the last loaded seed.
REQ-015 step_count  output  16  accepted outputs since the last seed load or reset, saturating at 16'hFFFF.

Function
REQ-016 FSM states: IDLE, RUN, LOCK.
- rand_valid = 1 only in RUN.
- lockup = 1 only in LOCK.
REQ-017 Transitions out of IDLE (evaluated when seed_load = 0):
- enable = 1 and state != 0 -> RUN.
- enable = 1 and state == 0 -> LOCK.
REQ-018 Transitions out of RUN:
- enable = 0 -> IDLE, state held.
REQ-019 Transitions out of LOCK:
- only a seed_load with non-zero seed_in exits LOCK.
- target is RUN if enable = 1, else IDLE.
REQ-020 seed_load has priority over advance and over the FSM transitions above.
- state <= seed_in; seed register <= seed_in; step_count <= 0; no period_done.
- Next FSM state: LOCK if seed_in == 0 and enable = 1; IDLE if enable = 0; otherwise RUN.
REQ-021 Advance occurs only in RUN when rand_valid & rand_ready & ~seed_load; one step per accepted output.
- New value appears on rand_out the cycle after acceptance (latency 1).
REQ-022 Fibonacci step: fb = XOR-reduce(state & TAPS); next = {fb, state[WIDTH-1:1]}.
REQ-023 Galois step: next = (state >> 1) XOR ({WIDTH{state[0]}} & TAPS).
REQ-024 rand_out SHALL NOT change while rand_valid = 1 and rand_ready = 0.
REQ-025 period_done pulses for one cycle when an advance produces next == seed register.
- step_count increments on the same advance.
REQ-026 step_count saturates at 16'hFFFF; the wrap-around to seed does not clear it.
REQ-027 An advance to all-zero (possible only with non-maximal TAPS) forces LOCK next cycle.
REQ-028 enable falling in the same cycle as an accept: the advance happens, then FSM goes to IDLE.

Reset
REQ-029 While rst_n = 0, asynchronously:
- state = SEED, seed register = SEED, FSM = IDLE.
- rand_valid = 0, lockup = 0, period_done = 0, step_count = 0.
REQ-030 rst_n asserted mid-operation aborts any pending handshake; no advance is counted for that cycle.
REQ-031 Outputs after reset release follow REQ-016..REQ-028 from the first rising edge.

Verification
REQ-032 Sequence check (defaults, rst_n released, enable = 1, rand_ready = 1):
- rand_out = 000001, 100000, 010000, 001000, 000100, 000010, 100001 on consecutive cycles.
REQ-033 Period check (defaults, free-running accept):
- period_done pulses exactly once per 63 accepts; step_count = 63 at the first pulse.
REQ-034 Backpressure: hold rand_ready = 0 for 5 cycles in RUN.
- rand_out stable, rand_valid = 1, step_count unchanged; resumes advancing on ready.
REQ-035 Lockup: seed_load with seed_in = 0, enable = 1.
- lockup = 1, rand_valid = 0.
- seed_load 6'b101010 -> lockup = 0, rand_out = 101010, step_count = 0.
REQ-036 Galois mode (MODE = 1, TAPS = 6'b110000, seed 000001):
- next rand_out = 110000, then 011000.
- Async reset mid-stream -> rand_out = SEED and rand_valid = 0 immediately.
